bitmap_ram_arbiter: RTL and testbench
=====================================

BITMAP_RAM_ARBITER -- requirements
Module: bitmap_ram_arbiter

Interface
REQ-001 Parameter BMP_W, default 128, bitmap width in pixels (power of two).
REQ-002 Parameter BMP_H, default 128, bitmap height in pixels (power of two).
REQ-003 Parameter ADDR_W, default 14, equal to log2(BMP_W*BMP_H).
REQ-004 Parameter BG_COLOR, default 8'h00, colour shown outside the bitmap window.
REQ-005 clk  in  1  single system clock (80 MHz pixel clock); all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 video_on  in  1  visible-area flag from the sync generator.
REQ-008 pixel_x, pixel_y  in  11 each  current pixel coordinates.
REQ-009 wr_valid  in  1; wr_ready  out  1; wr_addr  in  ADDR_W; wr_data  in  8  -- single-pixel write port, valid/ready handshake.
REQ-010 clr_start  in  1  request to fill the whole bitmap; clr_color  in  8  fill colour; clr_busy  out  1  fill in progress.
REQ-011 mem_en, mem_we  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  8; mem_rdata  in  8  -- single-port synchronous RAM, 1-cycle read latency.
REQ-012 rgb  out  8  registered pixel colour.

Function
REQ-013 disp_req = video_on AND pixel_x < BMP_W AND pixel_y < BMP_H; display address = {pixel_y[log2 BMP_H-1:0], pixel_x[log2 BMP_W-1:0]}.
REQ-014 Priority per cycle: display read > clear write > port write; exactly one RAM access per cycle at most.
REQ-015 Display read: mem_en=1, mem_we=0, mem_addr=display address, combinational in the same cycle as disp_req.
REQ-016 rgb latency 2 edges: disp_req delayed one cycle (disp_d1); at the next edge rgb <= disp_d1 ? mem_rdata : BG_COLOR.
REQ-017 FSM states IDLE, CLEAR.
REQ-018 IDLE -> CLEAR on clr_start=1; clr_color latched, clear counter set to 0, clr_busy=1 from the next cycle.
REQ-019 CLEAR: in each cycle with disp_req=0, write latched colour to the counter address and increment; cycles with disp_req=1 stall the counter.
REQ-020 CLEAR -> IDLE in the cycle after writing address 2^ADDR_W-1; clr_busy=0 in IDLE.
REQ-021 clr_start while in CLEAR is ignored; clr_color changes during CLEAR have no effect.
REQ-022 wr_ready = (state==IDLE) AND NOT disp_req AND NOT clr_start; write is committed (mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data) in the cycle wr_valid AND wr_ready.
REQ-023 Simultaneous clr_start and wr_valid in IDLE: write is not accepted; clear starts; the writer retries after clr_busy falls.
REQ-024 Idle cycles (no grant): mem_en=0, mem_we=0, mem_addr/mem_wdata hold previous value.
REQ-025 wr_ready is combinational from inputs and state; wr_valid/addr/data stay stable until accepted.

Reset
REQ-026 During rst_n=0: state=IDLE, clear counter=0, latched colour=0, disp_d1=0, rgb=BG_COLOR, clr_busy=0, mem_en=0, mem_we=0.
REQ-027 Reset asserted mid-clear aborts it; no further RAM writes; partially cleared content is retained.
REQ-028 After release, first display read is possible in the first cycle with disp_req=1.

Structure
REQ-029 FSM state encoding, BG_COLOR default and bitmap geometry constants live in a shared video package used with the sync generator and bitmap generator.
REQ-030 One sub-module: bitmap_clear_seq (FSM + address counter), with the arbitration mux in the parent.

Verification
REQ-031 Reset: hold rst_n=0 5 cycles -> rgb=8'h00, clr_busy=0, mem_we=0; release -> wr_ready=1 with video_on=0.
REQ-032 Display: RAM[{7'd3,7'd5}]=8'hE3, drive video_on=1, x=5, y=3 -> mem_addr=0x0185 same cycle, rgb=8'hE3 after 2 edges; x=200 -> rgb=8'h00.
REQ-033 Write blocked: video_on=1, x=10, y=10, wr_valid=1 -> wr_ready=0, mem_we=0; move x to 500 -> write accepted that cycle.
REQ-034 Clear: video_on=0, clr_start=1, clr_color=8'h1C -> clr_busy for exactly 16384 cycles, every RAM word =8'h1C, then wr_ready=1.
REQ-035 Clear with display: clr during frame scan -> counter stalls on disp_req cycles; total writes still 16384; no display read lost.
REQ-036 Mid-clear reset at counter 100 -> addresses 0..99 =clr colour, 100+ unchanged, state IDLE.

Source files
------------

// File: rtl/bitmap_ram_arbiter_pkg.sv
// Shared video constants for the bitmap path.
// Geometry defaults, background colour and clear FSM states.
package bitmap_ram_arbiter_pkg;

  localparam int BMP_W_DEF  = 128;
  localparam int BMP_H_DEF  = 128;
  localparam int ADDR_W_DEF = 14;

  localparam logic [7:0] BG_COLOR_DEF = 8'h00;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/bitmap_clear_seq.sv
// Bitmap fill sequencer: walks every RAM address once.
// Stalls on display cycles so the scan-out never loses a read.
module bitmap_clear_seq
  import bitmap_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  input  logic [7:0]        clr_color,
  input  logic              disp_req,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        color
);

  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [ADDR_W-1:0] ONE  =
    {{(ADDR_W-1){1'b0}}, 1'b1};

  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [7:0]        col, col_nxt;

  // State, counter and latched colour registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      col   <= col_nxt;
    end
  end

  // Next state: start on request, advance only on free cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    col_nxt   = col;
    unique case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
          col_nxt   = clr_color;
        end
      end
      CLEAR: begin
        if (!disp_req) begin
          cnt_nxt = cnt + ONE;
          if (cnt == LAST) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy  = (state == CLEAR);
  assign wr_en = busy && !disp_req;
  assign addr  = cnt;
  assign color = col;

endmodule

// File: rtl/bitmap_ram_arbiter.sv
// Single-port bitmap RAM arbiter: display > clear > pixel write.
// Produces the registered pixel colour two edges after request.
module bitmap_ram_arbiter
  import bitmap_ram_arbiter_pkg::*;
#(
  parameter int         BMP_W    = BMP_W_DEF,
  parameter int         BMP_H    = BMP_H_DEF,
  parameter int         ADDR_W   = ADDR_W_DEF,
  parameter logic [7:0] BG_COLOR = BG_COLOR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              video_on,
  input  logic [10:0]       pixel_x,
  input  logic [10:0]       pixel_y,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              clr_start,
  input  logic [7:0]        clr_color,
  output logic              clr_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        rgb
);

  localparam int XW = $clog2(BMP_W);
  localparam int YW = $clog2(BMP_H);

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [7:0]        clr_wdata;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              disp_d1;

  assign disp_req = video_on
                 && (32'(pixel_x) < 32'(BMP_W))
                 && (32'(pixel_y) < 32'(BMP_H));

  assign disp_addr = {pixel_y[YW-1:0], pixel_x[XW-1:0]};

  bitmap_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_start(clr_start),
    .clr_color(clr_color),
    .disp_req (disp_req),
    .busy     (clr_busy),
    .wr_en    (clr_we),
    .addr     (clr_addr),
    .color    (clr_wdata)
  );

  assign wr_ready = rst_n && !clr_busy
                 && !disp_req && !clr_start;

  // One RAM grant per cycle; address/data hold when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (rst_n) begin
      if (disp_req) begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end else if (clr_we) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_addr;
        mem_wdata = clr_wdata;
      end else if (wr_valid && wr_ready) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
    end
  end

  // Remember the last driven address/data for idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  // Pixel pipeline: request delay, then RAM data or background.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_d1 <= 1'b0;
      rgb     <= BG_COLOR;
    end else begin
      disp_d1 <= disp_req;
      rgb     <= disp_d1 ? mem_rdata : BG_COLOR;
    end
  end

endmodule

// File: tb/tb_bitmap_ram_arbiter.sv
// Bench for bitmap_ram_arbiter: RAM model, bitmap model,
// per-cycle output compare and directed scenarios.
module tb_bitmap_ram_arbiter;

  localparam int N = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_n = 1'b0;
  logic        video_on = 1'b0;
  logic [10:0] pixel_x = '0;
  logic [10:0] pixel_y = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [13:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        clr_start = 1'b0;
  logic [7:0]  clr_color = '0;
  logic        clr_busy;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  rgb;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bitmap_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rgb(rgb)
  );

  function automatic logic [7:0] pat(input int i);
    logic [13:0] a;
    a = i[13:0];
    return (a == 14'h0185) ? 8'hE3 : (a[7:0] ^ 8'h5A);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad < 40)
        $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous RAM, one-cycle read latency.
  logic [7:0] ram [0:N-1];
  always @(posedge clk) begin
    if (!init_n) begin
      for (int i = 0; i < N; i++) ram[i] = pat(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Count clear writes seen on the RAM port.
  int nwr = 0;
  always @(posedge clk)
    if (rst_n && mem_en && mem_we && clr_busy) nwr <= nwr + 1;

  // Behavioural model: bitmap contents and expected pixels.
  logic [7:0]  gold [0:N-1];
  logic        m_clearing;
  int          m_cnt;
  logic [7:0]  m_color;
  logic [13:0] m_last_addr;
  logic [7:0]  m_last_wdata;
  logic        p_d1;
  logic [7:0]  p_val, exp_rgb;

  function automatic logic disp_now();
    return rst_n && video_on && pixel_x < 128 && pixel_y < 128;
  endfunction

  function automatic logic [13:0] daddr();
    return {pixel_y[6:0], pixel_x[6:0]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (!init_n)
        for (int i = 0; i < N; i++) gold[i] = pat(i);
      m_clearing   <= 1'b0;
      m_cnt        <= 0;
      m_color      <= 8'h00;
      m_last_addr  <= '0;
      m_last_wdata <= '0;
      p_d1         <= 1'b0;
      p_val        <= 8'h00;
      exp_rgb      <= 8'h00;
    end else begin
      exp_rgb <= p_d1 ? p_val : 8'h00;
      p_d1    <= disp_now();
      p_val   <= gold[daddr()];
      if (disp_now()) begin
        m_last_addr <= daddr();
      end else if (m_clearing) begin
        gold[m_cnt]  <= m_color;
        m_last_addr  <= m_cnt[13:0];
        m_last_wdata <= m_color;
        m_cnt        <= m_cnt + 1;
        if (m_cnt == N - 1) m_clearing <= 1'b0;
      end else if (wr_valid && !clr_start) begin
        gold[wr_addr] <= wr_data;
        m_last_addr   <= wr_addr;
        m_last_wdata  <= wr_data;
      end
      if (!m_clearing && clr_start) begin
        m_clearing <= 1'b1;
        m_cnt      <= 0;
        m_color    <= clr_color;
      end
    end
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    logic        d, e_en, e_we, e_rdy;
    logic [13:0] e_addr;
    logic [7:0]  e_wd;
    d      = disp_now();
    e_en   = 1'b0;
    e_we   = 1'b0;
    e_addr = m_last_addr;
    e_wd   = m_last_wdata;
    e_rdy  = rst_n && !m_clearing && !d && !clr_start;
    if (d) begin
      e_en = 1'b1; e_addr = daddr();
    end else if (rst_n && m_clearing) begin
      e_en = 1'b1; e_we = 1'b1;
      e_addr = m_cnt[13:0]; e_wd = m_color;
    end else if (rst_n && wr_valid && e_rdy) begin
      e_en = 1'b1; e_we = 1'b1;
      e_addr = wr_addr; e_wd = wr_data;
    end
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("wr_ready", wr_ready, e_rdy);
    chk("clr_busy", clr_busy, m_clearing);
    chk("rgb", rgb, exp_rgb);
  end

  task automatic cmp_ram();
    int diffs = 0;
    for (int i = 0; i < N; i++)
      if (ram[i] !== gold[i]) diffs++;
    chk("ram_vs_model", diffs, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc, base, cnt_a, cnt_b;
    bit done;

    // Reset held five cycles.
    repeat (2) @(posedge clk);
    #1 init_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rgb", rgb, 8'h00);
    chk("rst_busy", clr_busy, 0);
    chk("rst_we", mem_we, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", wr_ready, 1);

    // Display read of a preloaded pixel.
    step();
    video_on = 1'b1; pixel_x = 11'd5; pixel_y = 11'd3;
    @(negedge clk);
    chk("disp_addr", mem_addr, 14'h0185);
    chk("disp_en", mem_en, 1);
    step();
    pixel_x = 11'd200;
    @(negedge clk);
    chk("disp_rgb", rgb, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("disp_rgb2", rgb, 8'hE3);
    @(posedge clk);
    @(negedge clk);
    chk("outside_rgb", rgb, 8'h00);

    // Write blocked by display, accepted outside the window.
    step();
    pixel_x = 11'd10; pixel_y = 11'd10;
    wr_valid = 1'b1; wr_addr = 14'h2000; wr_data = 8'h3C;
    @(negedge clk);
    chk("blk_ready", wr_ready, 0);
    chk("blk_we", mem_we, 0);
    step();
    pixel_x = 11'd500;
    @(negedge clk);
    chk("acc_ready", wr_ready, 1);
    chk("acc_we", mem_we, 1);
    step();
    wr_valid = 1'b0; video_on = 1'b0;
    @(negedge clk);
    chk("acc_ram", ram[14'h2000], 8'h3C);

    // Full clear, with a write colliding on the start cycle.
    step();
    clr_start = 1'b1; clr_color = 8'h1C;
    wr_valid = 1'b1; wr_addr = 14'h0010; wr_data = 8'h77;
    @(negedge clk);
    chk("coll_ready", wr_ready, 0);
    chk("coll_we", mem_we, 0);
    step();
    clr_start = 1'b0; clr_color = 8'hFF;
    cyc = 0;
    done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk);
      if (clr_busy) cyc++;
      else done = 1'b1;
    end
    chk("clr_cycles", cyc, N);
    chk("clr_ready", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    cnt_a = 0;
    for (int i = 0; i < N; i++)
      if (i != 16 && ram[i] != 8'h1C) cnt_a++;
    chk("clr_words", cnt_a, 0);
    chk("retry_word", ram[16], 8'h77);
    cmp_ram();

    // Clear while the frame is scanned.
    step();
    clr_start = 1'b1; clr_color = 8'hAA;
    video_on = 1'b1; pixel_y = 11'd0; pixel_x = 11'd0;
    base = nwr;
    step();
    clr_start = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40000 && !done; i++) begin
      pixel_x = (pixel_x + 11'd1) & 11'h0FF;
      if (pixel_x == 0) pixel_y = (pixel_y + 11'd1) & 11'h07F;
      @(negedge clk);
      if (!clr_busy) done = 1'b1;
      else step();
    end
    chk("scan_done", done, 1);
    step();
    video_on = 1'b0;
    @(negedge clk);
    chk("scan_writes", nwr - base, N);
    cnt_a = 0;
    for (int i = 0; i < N; i++)
      if (ram[i] != 8'hAA) cnt_a++;
    chk("scan_words", cnt_a, 0);
    cmp_ram();

    // Reset in the middle of a clear.
    step();
    clr_start = 1'b1; clr_color = 8'h55;
    base = nwr;
    step();
    clr_start = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      if (nwr - base == 100) done = 1'b1;
      else step();
    end
    chk("mid_reach", done, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_busy", clr_busy, 0);
    chk("mid_we", mem_we, 0);
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_ready", wr_ready, 1);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < N; i++) begin
      if (i < 100 && ram[i] != 8'h55) cnt_a++;
      if (i >= 100 && ram[i] != 8'hAA) cnt_b++;
    end
    chk("mid_low", cnt_a, 0);
    chk("mid_high", cnt_b, 0);
    chk("mid_99", ram[99], 8'h55);
    chk("mid_100", ram[100], 8'hAA);
    cmp_ram();

    // First display read right after reset release.
    step();
    video_on = 1'b1; pixel_x = 11'd1; pixel_y = 11'd0;
    @(negedge clk);
    chk("post_en", mem_en, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("post_rgb", rgb, 8'h55);
    step();
    video_on = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
